// File: rtl/key_pkg.sv
// Shared keypad definitions: key codes, entry-controller state encoding and
// active-low seven-segment patterns ({dp,g,f,e,d,c,b,a}).
package key_pkg;

  localparam logic [3:0] KEY_BSP = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hC;

  localparam int unsigned MaxLen = 8;

  typedef enum logic [0:0] {
    StEntry  = 1'b0,
    StCommit = 1'b1
  } state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_decoder.sv
// Decimal digit to active-low seven-segment pattern; dp is always off.
module seg_decoder
  import key_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad digit-entry controller: edits an 8-digit buffer, hands a committed entry
// to a valid/ready consumer and multiplexes the buffer onto an 8-digit display.
module key_entry_ctrl
  import key_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_len,
  output logic        err,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  len_q, len_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_len_q, out_len_d;
  logic        err_q, err_d;
  logic [DivW-1:0] div_q;
  logic [2:0]  idx_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    err_d       = 1'b0;
    unique case (state_q)
      StEntry: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (len_q == 4'(MaxLen)) begin
              err_d = 1'b1;
            end else begin
              buf_d = {buf_q[27:0], key_code};
              len_d = len_q + 4'd1;
            end
          end else if (key_code == KEY_BSP) begin
            if (len_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              buf_d = {4'h0, buf_q[31:4]};
              len_d = len_q - 4'd1;
            end
          end else if (key_code == KEY_CLR) begin
            buf_d = '0;
            len_d = '0;
          end else if (key_code == KEY_ENT) begin
            if (len_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              state_d     = StCommit;
              out_valid_d = 1'b1;
              out_data_d  = buf_q;
              out_len_d   = len_q;
            end
          end
        end
      end
      StCommit: begin
        // Keys are dropped silently while the consumer owns the entry.
        if (out_ready) begin
          state_d     = StEntry;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_len_d   = '0;
          buf_d       = '0;
          len_d       = '0;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEntry;
      buf_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      err_q       <= err_d;
    end
  end

  // Free-running scan, never touched by key handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  logic [3:0] scan_digit;
  logic       scan_blank;

  assign scan_digit = buf_q[{idx_q, 2'b00} +: 4];
  assign scan_blank = ({1'b0, idx_q} >= len_q);

  seg_decoder u_seg_decoder (
    .digit_i (scan_digit),
    .blank_i (scan_blank),
    .seg_o   (seg_out)
  );

  assign seg_an    = ~(8'h01 << idx_q);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: entry editing, commit handshake, reset and display scan.
module tb_key_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_len;
  logic        err;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int n_total = 0;
  int n_pass  = 0;

  key_entry_ctrl #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .err       (err),
    .seg_an    (seg_an),
    .seg_out   (seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One-cycle key pulse; returns on the negedge after the capturing posedge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_len", 32'(out_len), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_an", 32'(seg_an), 32'hFE);
    check("rst_seg", 32'(seg_out), 32'hFF);
    rst = 1'b0;

    // 1,2,3, enter with consumer ready
    out_ready = 1'b1;
    press(4'h1); press(4'h2); press(4'h3); press(4'hC);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", out_data, 32'h00000123);
    check("t1_len", 32'(out_len), 32'h3);
    @(negedge clk);
    check("t1_drop_valid", 32'(out_valid), 32'h0);
    check("t1_drop_data", out_data, 32'h0);
    check("t1_drop_len", 32'(out_len), 32'h0);
    press(4'hC);
    check("t1_empty_ent_err", 32'(err), 32'h1);
    check("t1_empty_ent_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Overflow: nine digits, err only on the ninth
    for (int i = 1; i <= 9; i++) begin
      press(4'(i));
      check("t2_digit_err", 32'(err), (i == 9) ? 32'h1 : 32'h0);
    end
    press(4'hC);
    check("t2_valid", 32'(out_valid), 32'h1);
    check("t2_data", out_data, 32'h12345678);
    check("t2_len", 32'(out_len), 32'h8);

    // Held commit: keys ignored, outputs stable
    for (int i = 0; i < 10; i++) begin
      press(4'(i));
      check("t3_hold_err", 32'(err), 32'h0);
      check("t3_hold_valid", 32'(out_valid), 32'h1);
      check("t3_hold_data", out_data, 32'h12345678);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_xfer_valid", 32'(out_valid), 32'h0);
    check("t3_xfer_data", out_data, 32'h0);

    // Backspace underflow and enter at zero length
    press(4'h4); press(4'h5);
    press(4'hA);
    check("t4_bsp1_err", 32'(err), 32'h0);
    press(4'hA);
    check("t4_bsp2_err", 32'(err), 32'h0);
    press(4'hA);
    check("t4_bsp3_err", 32'(err), 32'h1);
    press(4'hC);
    check("t4_ent0_err", 32'(err), 32'h1);
    check("t4_ent0_valid", 32'(out_valid), 32'h0);
    press(4'h4); press(4'h5); press(4'hA); press(4'hC);
    check("t4_bsp_data", out_data, 32'h4);
    check("t4_bsp_len", 32'(out_len), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Clear without err, ignored codes
    press(4'h7); press(4'h8); press(4'hB);
    check("t5_clr_err", 32'(err), 32'h0);
    press(4'hC);
    check("t5_clr_empty_err", 32'(err), 32'h1);
    press(4'hD);
    check("t5_ign_err", 32'(err), 32'h0);
    press(4'h6); press(4'hF); press(4'hC);
    check("t5_ign_data", out_data, 32'h6);
    check("t5_ign_len", 32'(out_len), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-commit, key in first cycle after release
    press(4'h5); press(4'hC);
    check("t6_pre_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_an", 32'(seg_an), 32'hFE);
    check("t6_rst_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h9;
    @(negedge clk);
    key_code = 4'hC;
    @(negedge clk);
    key_valid = 1'b0;
    check("t6_post_valid", 32'(out_valid), 32'h1);
    check("t6_post_data", out_data, 32'h9);
    check("t6_post_len", 32'(out_len), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Display scan of 0x27 with SCAN_DIV=4
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_seg", 32'(seg_out), 32'hFF);
    rst = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h2;
    @(negedge clk);
    key_code = 4'h7;
    @(negedge clk);
    key_valid = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      int idx;
      idx = (c / 4) % 8;
      check("t7_scan_an", 32'(seg_an), 32'(an_tab[idx]));
      check("t7_scan_seg", 32'(seg_out),
            (idx == 0) ? 32'hF8 : (idx == 1) ? 32'hA4 : 32'hFF);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per display digit slot (minimum 2).
REQ-002 SHALL have port clk, input, 1, system clock; all state on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port key_valid, input, 1, single-cycle pulse qualifying key_code.
REQ-005 SHALL have port key_code, input, 4, decoded keypad value 0x0-0xF.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts committed entry.
REQ-007 SHALL have port out_valid, output, 1, committed entry available.
REQ-008 SHALL have port out_data, output, 32, committed digits; nibble 0 is the last digit entered.
REQ-009 SHALL have port out_len, output, 4, committed digit count, 1-8.
REQ-010 SHALL have port err, output, 1, single-cycle pulse on a rejected key.
REQ-011 SHALL have port seg_an, output, 8, digit enables, active-low.
REQ-012 SHALL have port seg_out, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-013 SHALL implement two states: ENTRY (editing) and COMMIT (holding the result for the consumer).
REQ-014 SHALL map key codes as follows: 0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD-0xF ignored (no err, no change).
REQ-015 In ENTRY with len<8, a digit SHALL shift the buffer left one nibble, insert the digit at nibble 0 and increment len; the update is visible the cycle after key_valid.
REQ-016 In ENTRY with len==8, a digit SHALL leave buffer and len unchanged and pulse err the next cycle.
REQ-017 In ENTRY with len>0, backspace SHALL shift the buffer right one nibble, zero-filling nibble 7, and decrement len; with len==0 it SHALL pulse err.
REQ-018 Clear SHALL zero the buffer and set len=0 from any len, without err.
REQ-019 In ENTRY with len>0, enter SHALL go to COMMIT with out_valid=1, out_data=buffer and out_len=len the next cycle; with len==0 it SHALL pulse err and stay in ENTRY.
REQ-020 In COMMIT, out_valid, out_data and out_len SHALL hold stable until a cycle with out_valid&&out_ready.
REQ-021 In that transfer cycle the block SHALL go to ENTRY next cycle with out_valid=0, buffer=0 and len=0.
REQ-022 In COMMIT, key_valid SHALL be ignored, with no err.
REQ-023 out_data and out_len SHALL read 0 whenever out_valid=0.
REQ-024 The scan divider SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL advance the scan index 0..7 and wrap from 7 to 0.
REQ-025 seg_an SHALL be ~(1<<idx), with exactly one digit enabled at a time.
REQ-026 When idx<len, seg_out SHALL show nibble idx of the buffer; otherwise seg_out SHALL be 0xFF (blank). The dp bit is always 1.
REQ-027 Digit patterns SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
REQ-028 In COMMIT, the display SHALL continue to show the held buffer.
REQ-029 Key handling SHALL be independent of scan timing; a key never stalls the scan.

Reset
REQ-030 While rst is high, the block SHALL hold: state=ENTRY, buffer=0, len=0, out_valid=0, out_data=0, out_len=0, err=0, divider=0, idx=0, seg_an=0xFE, seg_out=0xFF.
REQ-031 Reset asserted in COMMIT SHALL drop out_valid immediately and discard the entry.
REQ-032 A key_valid in the first cycle after reset release SHALL be processed normally.

Structure
REQ-033 Shared package key_pkg SHALL hold the key code constants (KEY_BSP=0xA, KEY_CLR=0xB, KEY_ENT=0xC), the state encoding, and the segment pattern constants including SEG_BLANK=0xFF.
REQ-034 A sub-module seg_decoder (4-bit digit plus blank flag -> 8-bit active-low pattern) SHALL be used for the display path; key_pkg is shared with the keypad scanner.

Verification
REQ-035 Digits 1,2,3 then enter, out_ready=1 -> out_valid one cycle, out_data=0x00000123, out_len=3; then len=0.
REQ-036 Nine digits 1..9 -> buffer=0x12345678, len=8, err pulses once on the digit 9.
REQ-037 Digits 4,5, backspace, backspace, backspace -> buffer 0x4 then 0; err on the third backspace; enter at len 0 -> err, out_valid stays 0.
REQ-038 Commit with out_ready=0 for 10 cycles plus digit keys injected -> outputs stable, no err; out_ready=1 -> transfer in one cycle.
REQ-039 SCAN_DIV=4, len=2, buffer=0x27 -> seg_an steps FE,FD,...,7F every 4 cycles; seg_out = F8,A4, then FF for idx 2-7.
REQ-040 rst asserted mid-COMMIT -> out_valid=0 and seg_an=0xFE immediately; entry resumes empty after release.
